// File: rtl/paint_pkg.sv
// Frame-buffer geometry, colour constants, engine state type and the
// shift-add pixel address helper shared by the drawing and scanout stages.
package paint_pkg;

   localparam int unsigned H_RES   = 160;
   localparam int unsigned V_RES   = 120;
   localparam int unsigned ADDR_W  = 15;
   localparam int unsigned COLOR_W = 12;

   localparam logic [COLOR_W-1:0] BG_COLOR = 12'hFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // y*160 + x without a multiplier: 160 = 128 + 32.
   function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [7:0] x,
                                                    input logic [6:0] y);
      logic [ADDR_W-1:0] w_y;
      logic [ADDR_W-1:0] w_x;
      w_y = {{(ADDR_W-7){1'b0}}, y};
      w_x = {{(ADDR_W-8){1'b0}}, x};
      return (w_y << 7) + (w_y << 5) + w_x;
   endfunction

endpackage

// File: rtl/brush_stamp.sv
// Stamps a clipped (2r+1)x(2r+1) square brush into the frame buffer,
// one pixel per granted cycle, in raster order.
module brush_stamp
   import paint_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [7:0]         cx,
   input  logic [6:0]         cy,
   input  logic [2:0]         radius,
   input  logic [COLOR_W-1:0] color,
   input  logic               erase,
   output logic               busy,
   output logic               done,
   input  logic               mem_gnt,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_a,
   output logic [COLOR_W-1:0] mem_wd,
   output state_t             o_dbg_state
);

   // Handshake: the engine presents a write every WRITE cycle; it is taken
   // (mem_we high, counters advance) only in a cycle where mem_gnt is high.

   localparam logic signed [8:0] X_MAX = 9'(H_RES - 1);
   localparam logic signed [8:0] Y_MAX = 9'(V_RES - 1);

   state_t r_state;
   state_t w_next;

   logic [7:0]         r_cx;
   logic [6:0]         r_cy;
   logic [2:0]         r_rad;
   logic [COLOR_W-1:0] r_color;
   logic [7:0]         r_x0;
   logic [7:0]         r_x1;
   logic [6:0]         r_y1;
   logic [7:0]         r_x;
   logic [6:0]         r_y;
   logic [ADDR_W-1:0]  r_row;

   logic signed [8:0] w_cx_s;
   logic signed [8:0] w_cy_s;
   logic signed [8:0] w_r_s;
   logic signed [8:0] w_xlo;
   logic signed [8:0] w_xhi;
   logic signed [8:0] w_ylo;
   logic signed [8:0] w_yhi;
   logic [7:0]        w_x0;
   logic [7:0]        w_x1;
   logic [6:0]        w_y0;
   logic [6:0]        w_y1;
   logic              w_offscreen;
   logic              w_last_x;
   logic              w_last_y;
   logic              w_step;

   // Clip bounds from the latched request; signed so cx-r below zero clamps.
   assign w_cx_s = signed'({1'b0, r_cx});
   assign w_cy_s = signed'({2'b00, r_cy});
   assign w_r_s  = signed'({6'd0, r_rad});
   assign w_xlo  = w_cx_s - w_r_s;
   assign w_xhi  = w_cx_s + w_r_s;
   assign w_ylo  = w_cy_s - w_r_s;
   assign w_yhi  = w_cy_s + w_r_s;

   always_comb begin
      w_x0 = (w_xlo < 9'sd0)  ? 8'd0        : w_xlo[7:0];
      w_x1 = (w_xhi > X_MAX)  ? X_MAX[7:0]  : w_xhi[7:0];
      w_y0 = (w_ylo < 9'sd0)  ? 7'd0        : w_ylo[6:0];
      w_y1 = (w_yhi > Y_MAX)  ? Y_MAX[6:0]  : w_yhi[6:0];
   end

   assign w_offscreen = (r_cx >= 8'(H_RES)) || (r_cy >= 7'(V_RES));
   assign w_last_x    = (r_x == r_x1);
   assign w_last_y    = (r_y == r_y1);
   assign w_step      = (r_state == ST_WRITE) && mem_gnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      mem_we = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (start) w_next = ST_SETUP;
         end
         ST_SETUP: begin
            busy   = 1'b1;
            w_next = w_offscreen ? ST_DONE : ST_WRITE;
         end
         ST_WRITE: begin
            busy   = 1'b1;
            mem_we = mem_gnt;
            if (w_step && w_last_x && w_last_y) w_next = ST_DONE;
         end
         ST_DONE: begin
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cx    <= '0;
         r_cy    <= '0;
         r_rad   <= '0;
         r_color <= '0;
         r_x0    <= '0;
         r_x1    <= '0;
         r_y1    <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_row   <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_cx    <= cx;
                  r_cy    <= cy;
                  r_rad   <= radius;
                  r_color <= erase ? BG_COLOR : color;
               end
            end
            ST_SETUP: begin
               r_x0  <= w_x0;
               r_x1  <= w_x1;
               r_y1  <= w_y1;
               r_x   <= w_x0;
               r_y   <= w_y0;
               r_row <= xy_to_addr(8'd0, w_y0);
            end
            ST_WRITE: begin
               if (w_step) begin
                  if (!w_last_x) begin
                     r_x <= r_x + 8'd1;
                  end else if (!w_last_y) begin
                     r_x   <= r_x0;
                     r_y   <= r_y + 7'd1;
                     r_row <= r_row + ADDR_W'(H_RES);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign mem_a       = r_row + {{(ADDR_W-8){1'b0}}, r_x};
   assign mem_wd      = r_color;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_brush_stamp.sv
// Randomized scoreboard bench for brush_stamp: a raster reference model fills
// an expected-write queue; a negedge monitor pops and compares.
module tb_brush_stamp;
   import paint_pkg::*;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        start  = 1'b0;
   logic [7:0]  cx     = '0;
   logic [6:0]  cy     = '0;
   logic [2:0]  radius = '0;
   logic [11:0] color  = '0;
   logic        erase  = 1'b0;
   logic        mem_gnt = 1'b0;
   logic        busy;
   logic        done;
   logic        mem_we;
   logic [14:0] mem_a;
   logic [11:0] mem_wd;
   state_t      dbg_state;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int t0 = 0;
   int exp_done = 0;
   int n_wr = 0;
   bit active = 0;
   bit done_seen = 0;

   // {write cycle label[15:0], address[14:0], data[11:0]}
   logic [42:0] exp_q[$];
   bit          gnt_pat[0:1023];

   brush_stamp dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cx(cx), .cy(cy),
      .radius(radius), .color(color), .erase(erase), .busy(busy),
      .done(done), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_a(mem_a),
      .mem_wd(mem_wd), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
      end
   endtask

   // Monitor: label 1 is the cycle right after the start edge.
   always @(negedge clk) begin
      int          lbl;
      logic [42:0] e;
      lbl = cyc - t0 + 1;
      if (rst_n) begin
         if (active) check("busy", 32'(busy), 32'(lbl >= 1 && lbl < exp_done));
         if (mem_we) begin
            n_wr++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: addr %0d data 0x%0h at cycle %0d, no write expected",
                        mem_a, mem_wd, lbl);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr",  32'(mem_a),  32'(e[26:12]));
               check("wr_data",  32'(mem_wd), 32'(e[11:0]));
               check("wr_cycle", 32'(lbl),    32'(e[42:27]));
            end
         end
         if (done) begin
            done_seen = 1;
            if (!active) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done: done=1 at cycle %0d, expected 0", lbl);
            end else begin
               check("done_cycle", 32'(lbl), 32'(exp_done));
               check("writes_left_at_done", 32'(exp_q.size()), 32'd0);
            end
         end
      end
   end

   // gmode: 0 always granted, 1 grant low on cycles 3..5, 2 random grant.
   task automatic run_stamp(input int cxi, input int cyi, input int ri,
                            input logic [11:0] col, input logic er, input int gmode,
                            input bit noise, input int rst_after);
      int          x0, x1, y0, y1, lbl;
      logic [11:0] rc;
      bit          off;
      rc  = er ? 12'hFFF : col;
      off = (cxi >= 160) || (cyi >= 120);
      for (int i = 0; i < 1024; i++) begin
         if (gmode == 0)      gnt_pat[i] = 1;
         else if (gmode == 1) gnt_pat[i] = !(i >= 3 && i <= 5);
         else                 gnt_pat[i] = (i > 600) ? 1 : ($urandom_range(0, 99) < 70);
      end
      x0 = (cxi - ri < 0) ? 0 : cxi - ri;
      x1 = (cxi + ri > 159) ? 159 : cxi + ri;
      y0 = (cyi - ri < 0) ? 0 : cyi - ri;
      y1 = (cyi + ri > 119) ? 119 : cyi + ri;
      exp_q.delete();
      lbl = 2;
      if (off) begin
         exp_done = 2;
      end else begin
         for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
               while (!gnt_pat[lbl]) lbl++;
               exp_q.push_back({16'(lbl), 15'(y * 160 + x), rc});
               lbl++;
            end
         end
         exp_done = lbl;
      end

      cx = 8'(cxi); cy = 7'(cyi); radius = 3'(ri); color = col; erase = er;
      start = 1; mem_gnt = 1'($urandom_range(0, 1));
      n_wr = 0; done_seen = 0;
      @(posedge clk); #1;
      t0 = cyc; active = 1; start = 0;
      lbl = 1;
      while (!done_seen && lbl <= exp_done + 20) begin
         mem_gnt = gnt_pat[lbl];
         if (noise && lbl <= exp_done) begin
            start = 1'($urandom_range(0, 1));
            cx = 8'($urandom_range(0, 255)); cy = 7'($urandom_range(0, 127));
            radius = 3'($urandom_range(0, 7)); color = 12'($urandom);
            erase = 1'($urandom_range(0, 1));
         end else begin
            start = 0;
         end
         @(posedge clk); #1;
         lbl++;
         if (rst_after > 0 && n_wr == rst_after) begin
            start = 0; mem_gnt = 1; rst_n = 0;
            #1;
            check("rst_mem_we", 32'(mem_we), 32'd0);
            check("rst_busy",   32'(busy),   32'd0);
            check("rst_done",   32'(done),   32'd0);
            check("rst_state",  32'(dbg_state), 32'(ST_IDLE));
            active = 0;
            exp_q.delete();
            repeat (2) @(posedge clk);
            @(negedge clk) rst_n = 1;
            @(posedge clk); #1;
            return;
         end
      end
      start = 0;
      if (!done_seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: no done within %0d cycles, expected at cycle %0d", lbl, exp_done);
         exp_q.delete();
      end
      active = 0;
      mem_gnt = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 0;
      mem_gnt = 1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy",   32'(busy),   32'd0);
      check("reset_done",   32'(done),   32'd0);
      check("reset_mem_we", 32'(mem_we), 32'd0);
      check("reset_mem_a",  32'(mem_a),  32'd0);
      check("reset_mem_wd", 32'(mem_wd), 32'd0);
      check("reset_state",  32'(dbg_state), 32'(ST_IDLE));
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;

      run_stamp(80, 60, 1, 12'hF00, 0, 0, 0, 0);
      run_stamp(0, 0, 2, 12'h0A5, 0, 0, 0, 0);
      run_stamp(159, 119, 0, 12'h123, 1, 0, 0, 0);
      run_stamp(80, 60, 1, 12'hF00, 0, 1, 0, 0);
      run_stamp(200, 10, 3, 12'h777, 0, 0, 0, 0);
      run_stamp(80, 60, 1, 12'hF00, 0, 0, 0, 4);
      run_stamp(10, 10, 0, 12'h0F0, 0, 0, 0, 0);
      run_stamp(159, 0, 7, 12'h00F, 0, 2, 1, 0);
      run_stamp(0, 119, 7, 12'h5A5, 0, 2, 1, 0);
      run_stamp(40, 127, 2, 12'h321, 0, 2, 1, 0);
      for (int k = 0; k < 40; k++) begin
         run_stamp($urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 7),
                   12'($urandom), 1'($urandom_range(0, 3) == 0), 2, 1, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
